icache_ctrl: RTL and testbench

Direct-mapped, 256-line, one-word-per-line read cache controller for the fetch path. Accepts CPU read requests, checks the line's valid bit in the external 256×1 valid table (`cache_table`), compares tags, and on a miss refills from memory via a req/ack handshake. It owns the tag and data arrays internally and drives the valid table's write port for refill and flush.

---
 rtl/icache_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_icache_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped, 256-line, one-word-per-line fetch cache controller.
// Latency: hit responds 2 cycles after accept; miss responds 1 cycle after mem_ack.
// Backpressure: req_ready is high only in IDLE; the refill request holds until mem_ack.
// Optional: define ICACHE_STATS_EN to add the hit_cnt / miss_cnt outputs.
module icache_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [AW-1:0] req_addr,
  output logic          req_ready,
  output logic          resp_valid,
  output logic [DW-1:0] resp_data,
  input  logic          flush,
  output logic          busy,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          vt_we,
  output logic [7:0]    vt_addr,
  output logic          vt_wd,
  input  logic          vt_rd
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);

  localparam int TW = AW - 10;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    RESP,
    FLUSH
  } state_t;

  state_t state_q, state_d;

  // Registered word address of the request in flight (byte offset dropped).
  logic [AW-3:0] addr_q;
  logic [7:0]    idx;
  logic [TW-1:0] tag;
  logic          flush_pend;
  logic [7:0]    flush_cnt;

  // Internal tag and data storage; validity lives in the external table.
  logic [TW-1:0] tag_arr  [256];
  logic [DW-1:0] data_arr [256];

  // Per-cycle decisions produced by the FSM and consumed by the datapath.
  logic accept;
  logic lookup_hit;
  logic lookup_miss;
  logic refill_done;
  logic flush_take;
  logic hit;

  // The byte offset within a word carries no information for a word cache.
  logic unused_offset;
  assign unused_offset = ^req_addr[1:0];

  assign idx = addr_q[7:0];
  assign tag = addr_q[AW-3:8];
  assign hit = vt_rd && (tag_arr[idx] == tag);

  // State register; reset drops mem_req immediately by leaving REFILL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    busy        = 1'b1;
    mem_req     = 1'b0;
    mem_addr    = '0;
    vt_we       = 1'b0;
    vt_wd       = 1'b0;
    vt_addr     = idx;
    accept      = 1'b0;
    lookup_hit  = 1'b0;
    lookup_miss = 1'b0;
    refill_done = 1'b0;
    flush_take  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        // A pending or live flush wins over a waiting request.
        if (flush || flush_pend) begin
          flush_take = 1'b1;
          state_d    = FLUSH;
        end else if (req_valid) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          lookup_hit = 1'b1;
          state_d    = RESP;
        end else begin
          lookup_miss = 1'b1;
          state_d     = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q, 2'b00};
        if (mem_ack) begin
          vt_we       = 1'b1;
          vt_wd       = 1'b1;
          refill_done = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      FLUSH: begin
        vt_we   = 1'b1;
        vt_addr = flush_cnt;
        if (flush_cnt == 8'hFF) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the request address when it is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (accept) begin
      addr_q <= req_addr[AW-1:2];
    end
  end

  // Response word comes from the data array on a hit, from memory on a refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data <= '0;
    end else if (lookup_hit) begin
      resp_data <= data_arr[idx];
    end else if (refill_done) begin
      resp_data <= mem_rdata;
    end
  end

  // Remember a flush that arrives while busy; it is consumed on the next IDLE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if ((state_q != IDLE) && flush) begin
      flush_pend <= 1'b1;
    end else if (flush_take) begin
      flush_pend <= 1'b0;
    end
  end

  // Sweep index for the flush; wraps back to 0 after the last line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= 8'h00;
    end else if (state_q == FLUSH) begin
      flush_cnt <= flush_cnt + 8'h01;
    end
  end

  // Refill writes tag and data; an abandoned refill never reaches this point.
  always_ff @(posedge clk) begin
    if (refill_done) begin
      tag_arr[idx]  <= tag;
      data_arr[idx] <= mem_rdata;
    end
  end

`ifdef ICACHE_STATS_EN
  // Lookup outcome counters, free-running and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else begin
      if (lookup_hit) begin
        hit_cnt <= hit_cnt + 32'h1;
      end
      if (lookup_miss) begin
        miss_cnt <= miss_cnt + 32'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: vector table of reads plus flush/reset sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
// An external 256x1 valid table is modelled here, cleared by rst.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        flush;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        vt_we;
  logic [7:0]  vt_addr;
  logic        vt_wd;
  logic        vt_rd;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  icache_ctrl #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .flush     (flush),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .vt_we     (vt_we),
    .vt_addr   (vt_addr),
    .vt_wd     (vt_wd),
    .vt_rd     (vt_rd)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // External valid table
  logic vt_mem [256];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) vt_mem[k] <= 1'b0;
    end else if (vt_we) begin
      vt_mem[vt_addr] <= vt_wd;
    end
  end
  assign vt_rd = vt_mem[vt_addr];

  typedef struct {
    logic [31:0] addr;
    int          dly;
    logic [31:0] rdata;
    bit          miss;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts and ends on a falling edge with the controller idle.
  task automatic do_read(input string nm, input logic [31:0] addr, input int dly,
                         input logic [31:0] rdata, input bit miss, input logic [31:0] exp_d);
    logic [31:0] wa;
    wa = {addr[31:2], 2'b00};
    chk({nm, ":ready"}, {63'h0, req_ready}, 64'h1);
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    if (!miss) begin
      // stray ack outside REFILL must be ignored
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
    end
    #1;
    chk({nm, ":lookup"}, {53'h0, busy, req_ready, vt_we, addr[9:2]},
        {53'h0, 1'b1, 1'b0, 1'b0, addr[9:2]});
    @(negedge clk);
    mem_ack = 1'b0;
    if (!miss) begin
      exp_hits++;
      chk({nm, ":hit_resp"}, {30'h0, resp_valid, mem_req, resp_data},
          {30'h0, 1'b1, 1'b0, exp_d});
    end else begin
      exp_misses++;
      chk({nm, ":mem_req"}, {30'h0, mem_req, resp_valid, mem_addr},
          {30'h0, 1'b1, 1'b0, wa});
      repeat (dly) @(negedge clk);
      chk({nm, ":req_hold"}, {30'h0, mem_req, busy, mem_addr}, {30'h0, 1'b1, 1'b1, wa});
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      #1;
      chk({nm, ":vt_write"}, {54'h0, vt_we, vt_wd, vt_addr}, {54'h0, 1'b1, 1'b1, addr[9:2]});
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      chk({nm, ":miss_resp"}, {30'h0, resp_valid, mem_req, resp_data},
          {30'h0, 1'b1, 1'b0, exp_d});
    end
    @(negedge clk);
    chk({nm, ":idle"}, {61'h0, req_ready, resp_valid, busy}, {61'h0, 1'b1, 1'b0, 1'b0});
  endtask

  // Called on the falling edge of the first FLUSH cycle.
  task automatic flush_sweep(input string nm);
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("%s:sweep%0d", nm, i), {51'h0, vt_we, vt_wd, vt_addr, busy, req_ready},
          {51'h0, 1'b1, 1'b0, 8'(i), 1'b1, 1'b0});
      @(negedge clk);
    end
    chk({nm, ":done"}, {62'h0, busy, req_ready}, {62'h0, 1'b0, 1'b1});
  endtask

  initial begin
    vecs[0] = '{32'h0000_0040, 3, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{32'h0000_0040, 0, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2] = '{32'h0000_0440, 2, 32'h12345678, 1'b1, 32'h12345678};
    vecs[3] = '{32'h0000_0440, 0, 32'h0,        1'b0, 32'h12345678};
    vecs[4] = '{32'h0000_0040, 0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vecs[5] = '{32'hFFFF_FFFC, 1, 32'h0BADF00D, 1'b1, 32'h0BADF00D};
    vecs[6] = '{32'hFFFF_FFFF, 0, 32'h0,        1'b0, 32'h0BADF00D};
    vecs[7] = '{32'h0000_0043, 0, 32'h0,        1'b0, 32'hDEADBEEF};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    flush     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {56'h0, req_ready, resp_valid, busy, mem_req, vt_we, vt_wd, 2'b00},
        {56'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
    chk("reset_data", {resp_data, mem_addr}, 64'h0);
    chk("reset_vt_addr", {56'h0, vt_addr}, 64'h0);
    rst = 1'b0;

    // Table of reads, issued back to back
    for (int i = 0; i < 8; i++) begin
      do_read($sformatf("v%0d", i), vecs[i].addr, vecs[i].dly, vecs[i].rdata,
              vecs[i].miss, vecs[i].exp_d);
    end

    // Flush pulse while idle, then the cached line must miss
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    flush_sweep("flush_idle");
    do_read("post_flush", 32'h0000_0040, 2, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D);

    // Flush during REFILL with a request held waiting
    req_valid = 1'b1;
    req_addr  = 32'h0000_0080;
    @(negedge clk);
    req_addr  = 32'h0000_0040;
    @(negedge clk);
    exp_misses++;
    chk("fr:mem_req", {63'h0, mem_req}, 64'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    chk("fr:resp", {31'h0, resp_valid, resp_data}, {31'h0, 1'b1, 32'h55AA55AA});
    @(negedge clk);
    chk("fr:idle_gap", {62'h0, req_ready, busy}, {62'h0, 1'b1, 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    flush_sweep("flush_refill");
    do_read("fr_after", 32'h0000_0080, 1, 32'h0F0F0F0F, 1'b1, 32'h0F0F0F0F);

    // Reset while a refill is outstanding
    req_valid = 1'b1;
    req_addr  = 32'h0000_0100;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst:mem_req_up", {63'h0, mem_req}, 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst:async_drop", {61'h0, mem_req, busy, req_ready}, {61'h0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    do_read("rst_reread", 32'h0000_0100, 1, 32'h13579BDF, 1'b1, 32'h13579BDF);
    do_read("rst_hit", 32'h0000_0100, 0, 32'h0, 1'b0, 32'h13579BDF);

`ifdef ICACHE_STATS_EN
    chk("hit_cnt", {32'h0, hit_cnt}, {32'h0, 32'(exp_hits)});
    chk("miss_cnt", {32'h0, miss_cnt}, {32'h0, 32'(exp_misses)});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
